deserializer_rst: RTL and testbench

DESERIALIZER_RST -- requirements
Module: deserializer_rst

---
 rtl/deserializer_rst_if.sv | 24 ++
 rtl/deserializer_rst.sv | 96 +++++++++
 tb/tb_deserializer_rst.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_rst_if.sv
// Serial-in / parallel-out bundle for deserializer_rst: serial bit stream in,
// assembled word out with valid/ready handshake and status pulses.
interface deserializer_rst_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  i_data;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_busy;
  logic                  o_overflow;
  logic                  o_abort;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_data, o_valid, o_busy, o_overflow, o_abort
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_data, o_valid, o_busy, o_overflow, o_abort
  );
endinterface

// File: rtl/deserializer_rst.sv
// Collects DATA_WIDTH serial bits into a word and holds it until the consumer
// takes it; a gap in i_valid mid-word aborts, a word arriving while full is dropped.
module deserializer_rst #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  deserializer_rst_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  abort_q, abort_d;
  logic                  last_bit;

  // The incoming bit enters at the end that makes the first bit land on bit 0
  // (LSB first) or on bit DATA_WIDTH-1 (MSB first) once the word is full.
  always_comb begin
    if (MSB_FIRST) word = {sr_q[DATA_WIDTH-2:0], bus.i_data};
    else           word = {bus.i_data, sr_q[DATA_WIDTH-1:1]};
  end

  assign last_bit = bus.i_valid && (cnt_q == CW'(DATA_WIDTH - 1));

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q && !bus.i_ready;
    ovf_d   = 1'b0;
    abort_d = 1'b0;

    if (bus.i_valid) begin
      sr_d = word;
      if (last_bit) begin
        cnt_d   = '0;
        state_d = IDLE;
        // A slot frees up this edge if empty or being consumed right now.
        if (!valid_q || bus.i_ready) begin
          data_d  = word;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = RECV;
      end
    end else if (state_q == RECV) begin
      cnt_d   = '0;
      sr_d    = '0;
      state_d = IDLE;
      abort_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_busy     = (state_q == RECV);
  assign bus.o_overflow = ovf_q;
  assign bus.o_abort    = abort_q;
endmodule

// File: tb/tb_deserializer_rst.sv
// Scoreboard bench for deserializer_rst: words expected at the consumer are
// queued when sent and compared on every handshake.
module tb_deserializer_rst;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          drv_valid = 1'b0;
  logic          drv_data  = 1'b0;
  logic          drv_ready = 1'b0;
  logic          loop_en   = 1'b0;

  // Behavioural stand-in for serializer_rst: busy for DW cycles, LSB first.
  logic          ser_load = 1'b0;
  logic [DW-1:0] ser_word = '0;
  logic [DW-1:0] ser_sr   = '0;
  logic          ser_busy = 1'b0;
  int            ser_cnt  = 0;

  always @(posedge clk) begin
    if (rst) begin
      ser_busy <= 1'b0;
    end else if (ser_load) begin
      ser_sr   <= ser_word;
      ser_busy <= 1'b1;
      ser_cnt  <= 0;
    end else if (ser_busy) begin
      ser_sr  <= ser_sr >> 1;
      ser_cnt <= ser_cnt + 1;
      if (ser_cnt == DW - 1) ser_busy <= 1'b0;
    end
  end

  deserializer_rst_if #(.DATA_WIDTH(DW)) bus ();
  deserializer_rst_if #(.DATA_WIDTH(DW)) bus_m ();

  assign bus.i_valid   = loop_en ? ser_busy  : drv_valid;
  assign bus.i_data    = loop_en ? ser_sr[0] : drv_data;
  assign bus.i_ready   = drv_ready;
  assign bus_m.i_valid = bus.i_valid;
  assign bus_m.i_data  = bus.i_data;
  assign bus_m.i_ready = bus.i_ready;

  deserializer_rst #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  deserializer_rst #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_m (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_m)
  );

  int            total = 0;
  int            bad   = 0;
  int            hs_count    = 0;
  int            ovf_count   = 0;
  int            abort_count = 0;
  logic [DW-1:0] exp_q[$];

  // Handshake monitor: sampled on the falling edge, clear of input changes.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (!rst) begin
      if (bus.o_overflow) ovf_count++;
      if (bus.o_abort)    abort_count++;
      if (bus.o_valid && bus.i_ready) begin
        hs_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL handshake_unexpected: got %h, expected no word", bus.o_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.o_data !== exp_w) begin
            bad++;
            $display("FAIL handshake_data: got %h, expected %h", bus.o_data, exp_w);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic d);
    drv_valid = v;
    drv_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) drive(1'b1, w[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort, bus.o_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b o=%b a=%b d=%h, expected all 0",
               bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort, bus.o_data);
    end
    rst = 1'b0;
    drv_ready = 1'b1;
    repeat (3) drive(1'b0, 1'b1);
    total++;
    if ({bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort} !== 4'b0 || abort_count !== 0) begin
      bad++;
      $display("FAIL idle_hold: got v=%b b=%b o=%b a=%b, expected all 0",
               bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort);
    end
  endtask

  task automatic test_basic;
    logic [DW-1:0] bits;
    int hs0;
    bits = 8'b1010_0101;
    hs0  = hs_count;
    drv_ready = 1'b1;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < DW; i++) begin
      drive(1'b1, bits[i]);
      if (i == 0) begin
        total++;
        if (bus.o_busy !== 1'b1) begin
          bad++;
          $display("FAIL basic_busy: got %b, expected 1", bus.o_busy);
        end
      end
      if (i == DW - 2) begin
        total++;
        if (bus.o_valid !== 1'b0) begin
          bad++;
          $display("FAIL basic_early_valid: got %b, expected 0", bus.o_valid);
        end
      end
    end
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hA5 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_word: got v=%b d=%h b=%b, expected v=1 d=a5 b=0",
               bus.o_valid, bus.o_data, bus.o_busy);
    end
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_valid !== 1'b0 || hs_count - hs0 !== 1) begin
      bad++;
      $display("FAIL basic_one_cycle: got v=%b handshakes=%0d, expected v=0 handshakes=1",
               bus.o_valid, hs_count - hs0);
    end
  endtask

  task automatic test_overflow;
    int hs0, ov0;
    hs0 = hs_count;
    ov0 = ovf_count;
    drv_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h3C) begin
      bad++;
      $display("FAIL ovf_first_word: got v=%b d=%h, expected v=1 d=3c", bus.o_valid, bus.o_data);
    end
    send_word(8'hC3);
    total++;
    if (bus.o_overflow !== 1'b1 || bus.o_data !== 8'h3C || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pulse: got o=%b d=%h v=%b, expected o=1 d=3c v=1",
               bus.o_overflow, bus.o_data, bus.o_valid);
    end
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_overflow !== 1'b0 || bus.o_data !== 8'h3C || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovf_hold: got o=%b d=%h v=%b, expected o=0 d=3c v=1",
               bus.o_overflow, bus.o_data, bus.o_valid);
    end
    drv_ready = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_valid !== 1'b0 || hs_count - hs0 !== 1 || ovf_count - ov0 !== 1) begin
      bad++;
      $display("FAIL ovf_drain: got v=%b handshakes=%0d overflows=%0d, expected v=0 1 1",
               bus.o_valid, hs_count - hs0, ovf_count - ov0);
    end
  endtask

  task automatic test_abort;
    drv_ready = 1'b1;
    repeat (5) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_abort !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: got a=%b b=%b v=%b, expected a=1 b=0 v=0",
               bus.o_abort, bus.o_busy, bus.o_valid);
    end
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_abort !== 1'b0) begin
      bad++;
      $display("FAIL abort_one_cycle: got %b, expected 0", bus.o_abort);
    end
    exp_q.push_back(8'h81);
    send_word(8'h81);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h81) begin
      bad++;
      $display("FAIL abort_recover: got v=%b d=%h, expected v=1 d=81", bus.o_valid, bus.o_data);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    int ab0;
    ab0 = abort_count;
    drv_ready = 1'b0;
    send_word(8'h11);
    repeat (4) drive(1'b1, 1'b1);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got v=%b b=%b, expected v=1 b=1", bus.o_valid, bus.o_busy);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0);
    total++;
    if ({bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort, bus.o_data} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got v=%b b=%b o=%b a=%b d=%h, expected all 0",
               bus.o_valid, bus.o_busy, bus.o_overflow, bus.o_abort, bus.o_data);
    end
    rst = 1'b0;
    drv_ready = 1'b1;
    drive(1'b0, 1'b0);
    total++;
    if (bus.o_abort !== 1'b0 || abort_count !== ab0) begin
      bad++;
      $display("FAIL rstmid_no_abort: got a=%b aborts=%0d, expected 0 %0d",
               bus.o_abort, abort_count, ab0);
    end
    exp_q.push_back(8'hFF);
    send_word(8'hFF);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hFF) begin
      bad++;
      $display("FAIL rstmid_recover: got v=%b d=%h, expected v=1 d=ff", bus.o_valid, bus.o_data);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_msb_first;
    logic [DW-1:0] stream;
    stream = 8'b0000_0001;
    drv_ready = 1'b1;
    exp_q.push_back(8'h01);
    for (int i = 0; i < DW; i++) drive(1'b1, stream[i]);
    total++;
    if (bus_m.o_valid !== 1'b1 || bus_m.o_data !== 8'h80) begin
      bad++;
      $display("FAIL msb_first: got v=%b d=%h, expected v=1 d=80", bus_m.o_valid, bus_m.o_data);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_loopback;
    int ov0, ab0, n;
    ov0 = ovf_count;
    ab0 = abort_count;
    drv_ready = 1'b1;
    drv_valid = 1'b0;
    exp_q.push_back(8'h5A);
    loop_en  = 1'b1;
    ser_word = 8'h5A;
    ser_load = 1'b1;
    @(posedge clk);
    #1;
    ser_load = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 4 * DW) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h5A) begin
      bad++;
      $display("FAIL loopback_word: got v=%b d=%h after %0d cycles, expected v=1 d=5a",
               bus.o_valid, bus.o_data, n);
    end
    repeat (2) drive(1'b0, 1'b0);
    loop_en = 1'b0;
    total++;
    if (ovf_count !== ov0 || abort_count !== ab0) begin
      bad++;
      $display("FAIL loopback_clean: got overflows=%0d aborts=%0d, expected %0d %0d",
               ovf_count - ov0, abort_count - ab0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_msb_first();
    test_loopback();
    repeat (2) drive(1'b0, 1'b0);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d words outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
